// File: rtl/comp_op_requester.sv
// Initiator for the compOp start/ready handshake: queues operand requests, issues them one at a time,
// and holds each result for downstream. Optional macro COMP_OP_REQUESTER_TIMEOUT_EN adds an ISSUE watchdog.
module comp_op_requester #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_re1,
  input  logic [31:0] req_im1,
  input  logic [31:0] req_re2,
  input  logic [31:0] req_im2,
  input  logic        req_op,
  output logic        start,
  output logic        op,
  output logic [31:0] re1,
  output logic [31:0] im1,
  output logic [31:0] re2,
  output logic [31:0] im2,
  input  logic        ready,
  input  logic [31:0] re,
  input  logic [31:0] im,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_re,
  output logic [31:0] res_im,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = 129;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_check
    $error("comp_op_requester: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2, RESULT = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head_c;
  logic          push_c, pop_c;
  logic          start_q, start_d, op_q, op_d;
  logic [31:0]   re1_q, re1_d, im1_q, im1_d, re2_q, re2_d, im2_q, im2_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_re_q, res_re_d, res_im_q, res_im_d;
  logic          req_ready_q, req_ready_d, busy_q, busy_d;

`ifdef COMP_OP_REQUESTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_timeout_q, err_timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_q         <= tmo_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Request storage; contents only matter while the pointers say non-empty.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[PW-1:0]] <= {req_op, req_re1, req_im1, req_re2, req_im2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      start_q     <= 1'b0;
      op_q        <= 1'b0;
      re1_q       <= '0;
      im1_q       <= '0;
      re2_q       <= '0;
      im2_q       <= '0;
      res_valid_q <= 1'b0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      start_q     <= start_d;
      op_q        <= op_d;
      re1_q       <= re1_d;
      im1_q       <= im1_d;
      re2_q       <= re2_d;
      im2_q       <= im2_d;
      res_valid_q <= res_valid_d;
      res_re_q    <= res_re_d;
      res_im_q    <= res_im_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    start_d     = start_q;
    op_d        = op_q;
    re1_d       = re1_q;
    im1_d       = im1_q;
    re2_d       = re2_q;
    im2_d       = im2_q;
    res_valid_d = res_valid_q;
    res_re_d    = res_re_q;
    res_im_d    = res_im_q;
`ifdef COMP_OP_REQUESTER_TIMEOUT_EN
    tmo_d         = tmo_q;
    err_timeout_d = err_timeout_q;
`endif
    push_c = req_valid && req_ready_q;
    pop_c  = 1'b0;
    head_c = mem_q[rd_ptr_q[PW-1:0]];

    case (state_q)
      IDLE: begin
        if (wr_ptr_q != rd_ptr_q) begin
          pop_c   = 1'b1;
          {op_d, re1_d, im1_d, re2_d, im2_d} = head_c;
          start_d = 1'b1;
          state_d = ISSUE;
`ifdef COMP_OP_REQUESTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (ready) begin
          res_re_d    = re;
          res_im_d    = im;
          res_valid_d = 1'b1;
          start_d     = 1'b0;
          state_d     = GAP;
        end
`ifdef COMP_OP_REQUESTER_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          start_d       = 1'b0;
          state_d       = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      GAP: begin
        // Hold off until ready drops so a stale ready is never taken as the next result.
        if (res_ready) res_valid_d = 1'b0;
        if (!ready) state_d = res_valid_d ? RESULT : IDLE;
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_c) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    count_d     = wr_ptr_d - rd_ptr_d;
    req_ready_d = (count_d != FULL_CNT);
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  assign req_ready = req_ready_q;
  assign start     = start_q;
  assign op        = op_q;
  assign re1       = re1_q;
  assign im1       = im1_q;
  assign re2       = re2_q;
  assign im2       = im2_q;
  assign res_valid = res_valid_q;
  assign res_re    = res_re_q;
  assign res_im    = res_im_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_comp_op_requester.sv
// Directed bench for comp_op_requester: single request, backpressure/full FIFO, sticky ready, reset, watchdog.
module tb_comp_op_requester;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_op;
  logic [31:0] req_re1, req_im1, req_re2, req_im2;
  logic        start, op, ready, res_valid, res_ready, busy, err_timeout;
  logic [31:0] re1, im1, re2, im2, re, im, res_re, res_im;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  comp_op_requester #(.DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_re1(req_re1), .req_im1(req_im1), .req_re2(req_re2), .req_im2(req_im2),
    .req_op(req_op),
    .start(start), .op(op), .re1(re1), .im1(im1), .re2(re2), .im2(im2),
    .ready(ready), .re(re), .im(im),
    .res_valid(res_valid), .res_ready(res_ready), .res_re(res_re), .res_im(res_im),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] opnd(input int k, input int n);
    return (32'(n + 1) << 28) | 32'(k);
  endfunction

  task automatic push(input int k);
    req_valid = 1'b1;
    req_re1 = opnd(k, 0); req_im1 = opnd(k, 1); req_re2 = opnd(k, 2); req_im2 = opnd(k, 3);
    req_op  = k[0];
    tick();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for start, checks operands, answers with a one-cycle ready; res_ready is assumed high.
  task automatic serve(input int k);
    int n = 0;
    while (start !== 1'b1 && n < 32) begin
      tick();
      n++;
    end
    check($sformatf("start_seen_%0d", k), 32'(start), 32'd1);
    check($sformatf("re1_%0d", k), re1, opnd(k, 0));
    check($sformatf("im2_%0d", k), im2, opnd(k, 3));
    check($sformatf("op_%0d", k), 32'(op), 32'(k[0]));
    ready = 1'b1; re = 32'hA000_0000 | 32'(k); im = 32'hB000_0000 | 32'(k);
    tick();
    ready = 1'b0;
    check($sformatf("res_valid_%0d", k), 32'(res_valid), 32'd1);
    check($sformatf("res_re_%0d", k), res_re, 32'hA000_0000 | 32'(k));
    check($sformatf("res_im_%0d", k), res_im, 32'hB000_0000 | 32'(k));
    check($sformatf("start_drop_%0d", k), 32'(start), 32'd0);
    tick();
    check($sformatf("res_taken_%0d", k), 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0;
    req_re1 = '0; req_im1 = '0; req_re2 = '0; req_im2 = '0;
    ready = 1'b0; re = '0; im = '0; res_ready = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_start", 32'(start), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_re1", re1, 32'd0);
    rst = 1'b0;
    tick();

    // Single request with a 5-cycle responder.
    req_valid = 1'b1; req_op = 1'b0;
    req_re1 = 32'h41a80000; req_im1 = 32'h42400000; req_re2 = 32'h42920000; req_im2 = 32'hc1400000;
    tick();
    req_valid = 1'b0;
    check("t1_start_early", 32'(start), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_start", 32'(start), 32'd1);
    check("t1_re1", re1, 32'h41a80000);
    check("t1_im1", im1, 32'h42400000);
    check("t1_re2", re2, 32'h42920000);
    check("t1_im2", im2, 32'hc1400000);
    check("t1_op", 32'(op), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_hold_start", 32'(start), 32'd1);
      check("t1_hold_re2", re2, 32'h42920000);
    end
    ready = 1'b1; re = 32'h4503d000; im = 32'h454b4000;
    tick();
    ready = 1'b0;
    check("t1_start_drop", 32'(start), 32'd0);
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_re", res_re, 32'h4503d000);
    check("t1_res_im", res_im, 32'h454b4000);
    tick();
    check("t1_res_hold", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t1_res_clear", 32'(res_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Backpressure: 0 issued, 1..4 fill the FIFO; 5 is held at the full boundary.
    for (int k = 0; k < 5; k++) push(k);
    check("t2_full", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_re1 = opnd(5, 0); req_im1 = opnd(5, 1); req_re2 = opnd(5, 2); req_im2 = opnd(5, 3);
    req_op = 1'b1;
    check("t2_first_re1", re1, opnd(0, 0));
    ready = 1'b1; re = 32'hA000_0000; im = 32'hB000_0000;
    tick();
    ready = 1'b0;
    check("t2_first_res", res_re, 32'hA000_0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_no_second_start", 32'(start), 32'd0);
      check("t2_res_held", 32'(res_valid), 32'd1);
      check("t2_still_full", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    check("t2_res_taken", 32'(res_valid), 32'd0);
    tick();
    check("t2_pop_start", 32'(start), 32'd1);
    check("t2_space", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("t2_refull", 32'(req_ready), 32'd0);
    for (int k = 1; k < 6; k++) serve(k);
    check("t2_drained", 32'(busy), 32'd0);

    // Sticky ready held for three cycles.
    push(6);
    push(7);
    ready = 1'b1; re = 32'h1111_1111; im = 32'h2222_2222;
    tick();
    check("t3_capture", 32'(res_valid), 32'd1);
    check("t3_start_drop", 32'(start), 32'd0);
    re = 32'h3333_3333;
    tick();
    check("t3_single_res", 32'(res_valid), 32'd0);
    check("t3_res_kept", res_re, 32'h1111_1111);
    check("t3_gap_start1", 32'(start), 32'd0);
    tick();
    ready = 1'b0;
    check("t3_gap_start2", 32'(start), 32'd0);
    check("t3_no_recapture", 32'(res_valid), 32'd0);
    tick();
    check("t3_idle_start", 32'(start), 32'd0);
    serve(7);

    // Asynchronous reset in the middle of ISSUE.
    push(8);
    push(9);
    push(10);
    check("t4_in_issue", 32'(start), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("t4_start", 32'(start), 32'd0);
    check("t4_re1", re1, 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_req_ready", 32'(req_ready), 32'd1);
    check("t4_res_re", res_re, 32'd0);
    #2 rst = 1'b0;
    tick();
    tick();
    check("t4_fifo_empty", 32'(start), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);
    push(11);
    serve(11);

`ifdef COMP_OP_REQUESTER_TIMEOUT_EN
    // Watchdog: never answer request 12; request 13 must still go through.
    push(12);
    push(13);
    check("t5_start", 32'(start), 32'd1);
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    check("t5_not_yet", 32'(err_timeout), 32'd0);
    check("t5_still_start", 32'(start), 32'd1);
    tick();
    check("t5_err", 32'(err_timeout), 32'd1);
    check("t5_start_drop", 32'(start), 32'd0);
    check("t5_no_res", 32'(res_valid), 32'd0);
    serve(13);
    check("t5_sticky", 32'(err_timeout), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
